dp_block_ram: RTL and testbench
===============================

Name: dp_block_ram

Overview:
- Simple dual-port block RAM: one write port and one independent read port on a single clock.
- Generalises the existing single-port registered-output RAM with:
  - per-byte write enables;
  - selectable read latency (1 or 2);
  - read-valid qualification;
  - selectable read-during-write behaviour;
  - optional per-byte parity with error flag and error injection.
- Used as buffer/table storage behind FIFOs, packet buffers and lookup tables.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of one write-enable lane.
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from rd_en to rd_valid; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write in the same cycle: 0 = READ_OLD, 1 = WRITE_FIRST.
- PARITY_EN, 0, 1 = store one even-parity bit per byte and check it on read.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables.
- wr_data  in  DATA_WIDTH  write data.
- wr_perr_inj  in  1  invert stored parity of the enabled lanes on this write (test only; ignored if PARITY_EN=0).
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid for the read issued READ_LATENCY cycles earlier.
- rd_perr  out  1  parity error on the current rd_data; qualified by rd_valid; constant 0 if PARITY_EN=0.

Behaviour:
- Reset (rst_n low, asynchronous assert, release synchronous to clk):
  - rd_data = 0, rd_valid = 0, rd_perr = 0, all pipeline stages cleared.
  - Memory array and parity bits are NOT reset; contents after power-up are undefined.
- Write:
  - On a clk edge with wr_en=1, each lane i with wr_be[i]=1 stores wr_data lane i.
  - Its parity bit stores the XOR of that lane, inverted if wr_perr_inj=1.
  - Lanes with wr_be[i]=0 are unchanged.
  - wr_en=1 with wr_be=0 is a no-op.
- Read:
  - rd_en=1 samples rd_addr at edge T.
  - rd_valid=1 and data are presented after edge T+READ_LATENCY-1.
  - READ_LATENCY=1: registered array output, same timing as the existing RAM.
  - READ_LATENCY=2: adds one output register stage.
  - Back-to-back rd_en on every cycle is fully supported; throughput is 1 word/cycle, no stalls.
- Hold: rd_data and rd_perr keep their last value when rd_valid=0; outputs never return to 0 except on reset.
- Parity check (PARITY_EN=1):
  - rd_perr = OR over lanes of (recomputed lane parity XOR stored bit).
  - Computed at array-read time and delayed alongside the data.
- Same-cycle collision (wr_en & rd_en & wr_addr==rd_addr):
  - READ_OLD: return the pre-write contents and pre-write parity.
  - WRITE_FIRST: return the merged word, i.e. new lanes where wr_be=1 and old lanes elsewhere.
  - WRITE_FIRST parity for enabled lanes comes from the written parity bits, so wr_perr_inj is visible; disabled lanes use their stored parity.
- Non-same-cycle hazards get no forwarding:
  - A write on the cycle after a read to the same address does not alter that read's data at either latency.
  - A read issued at least one cycle after a write sees the new data.
- Address wrap: addresses are modulo depth by width; no out-of-range case exists.
- Reset mid-operation: all in-flight reads are dropped and no rd_valid is produced for them. A write on the same edge as reset assertion is not guaranteed.
- Elaboration check: DATA_WIDTH % BYTE_WIDTH != 0 or READ_LATENCY not in {1,2} must raise an error.

Decomposition:
- Package dp_ram_pkg:
  - localparams RDW_READ_OLD=0 and RDW_WRITE_FIRST=1;
  - function lane_parity(data, lanes) returning the per-lane XOR vector.
- One sub-module, ram_rd_pipe:
  - parameterised by latency and width;
  - carries {rd_data, rd_perr, rd_valid} through 0 or 1 extra register stages;
  - resets valid and data to 0.
- The array, byte-merge and collision mux stay in dp_block_ram.

Test Plan:
1. Reset then full write/read-back:
   - Stimulus: write addr k with data 32'hA5000000|k for all 1024 addresses, wr_be=4'hF; then read all 1024 back-to-back.
   - Required: rd_valid high for 1024 consecutive cycles, data matching, first valid at latency 1 and 2; rd_perr=0.
2. Byte enables:
   - Stimulus: write 32'h11223344 to addr 5, then 32'hAABBCCDD with wr_be=4'b0101.
   - Required: read of addr 5 returns 32'h11BB33DD.
3. Collision:
   - Stimulus: addr 7 holds 32'h0; same cycle write 32'hDEADBEEF (wr_be=4'hF) and read addr 7.
   - Required: RDW_MODE=0 returns 32'h0; RDW_MODE=1 returns 32'hDEADBEEF. A following read returns 32'hDEADBEEF in both modes.
4. Parity injection (PARITY_EN=1):
   - Stimulus: write addr 3 with wr_perr_inj=1, wr_be=4'b0010; then rewrite addr 3 without injection.
   - Required: first read gives rd_valid=1, rd_perr=1; read after the clean rewrite gives rd_perr=0. Reads of other addresses give rd_perr=0.
5. Reset mid-flight:
   - Stimulus: READ_LATENCY=2; issue reads on 2 consecutive cycles, then assert rst_n low asynchronously between edges.
   - Required: rd_valid, rd_data and rd_perr go to 0 immediately, and no rd_valid pulse appears after release until a new rd_en.
6. Hold:
   - Stimulus: single read returning 32'hCAFEF00D, then rd_en=0 for 5 cycles while writing other addresses.
   - Required: rd_data stays 32'hCAFEF00D and rd_valid=0 throughout.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared constants and the per-lane parity helper for the dual-port block RAM.
// lane_parity works on a fixed maximum width; callers zero-extend and truncate.
package dp_ram_pkg;

  localparam int RDW_READ_OLD    = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int PAR_MAX_DATA_W = 256;
  localparam int PAR_MAX_LANES  = 64;
  localparam int PAR_DW_BITS    = $clog2(PAR_MAX_DATA_W);
  localparam int PAR_LN_BITS    = $clog2(PAR_MAX_LANES);

  // Even parity (XOR) of each byte_w-bit lane; lanes beyond 'lanes' stay 0.
  function automatic logic [PAR_MAX_LANES-1:0] lane_parity(
    input logic [PAR_MAX_DATA_W-1:0] data,
    input int                        lanes,
    input int                        byte_w = 8
  );
    logic [PAR_MAX_LANES-1:0] par;
    int                       lane_idx;
    par = '0;
    for (int j = 0; j < PAR_MAX_DATA_W; j++) begin
      if (j < lanes * byte_w) begin
        lane_idx = j / byte_w;
        par[lane_idx[PAR_LN_BITS-1:0]] = par[lane_idx[PAR_LN_BITS-1:0]] ^ data[j[PAR_DW_BITS-1:0]];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Optional extra output stage for the RAM read path: LATENCY=1 passes straight
// through, LATENCY=2 adds one register that only loads on a valid beat.
module ram_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

  assign out_valid = (LATENCY > 1) ? valid_reg : in_valid;
  assign out_data  = (LATENCY > 1) ? data_reg  : in_data;

endmodule

// File: rtl/dp_block_ram.sv
// Simple dual-port block RAM with byte enables, selectable read latency and
// read-during-write mode, and optional per-byte even parity with injection.
module dp_block_ram
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter int PARITY_EN    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             wr_perr_inj,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             rd_perr
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("dp_block_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dp_block_ram: READ_LATENCY must be 1 or 2");
  end
  if (PARITY_EN != 0 && (DATA_WIDTH > PAR_MAX_DATA_W || LANES > PAR_MAX_LANES)) begin : g_bad_parity
    $error("dp_block_ram: word too wide for parity helper");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LANES-1:0]      wr_par;
  logic                  collide;
  logic [DATA_WIDTH-1:0] mem_q_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg;
  logic [LANES-1:0]      byp_be_reg;
  logic [LANES-1:0]      byp_par_reg;
  logic                  rd_valid1_reg;
  logic [LANES-1:0]      par_q;
  logic [DATA_WIDTH-1:0] merged_data;
  logic [LANES-1:0]      merged_par;
  logic [LANES-1:0]      chk_par;
  logic                  perr1;
  logic [DATA_WIDTH:0]   pipe_out;

  assign wr_par  = LANES'(lane_parity(PAR_MAX_DATA_W'(wr_data), LANES, BYTE_WIDTH))
                   ^ {LANES{wr_perr_inj}};
  assign collide = (RDW_MODE == RDW_WRITE_FIRST) && wr_en && rd_en && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Collision bypass is captured alongside the array read and merged after
  // the register, so the array itself keeps a plain registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q_reg     <= '0;
      byp_data_reg  <= '0;
      byp_be_reg    <= '0;
      byp_par_reg   <= '0;
      rd_valid1_reg <= 1'b0;
    end else begin
      rd_valid1_reg <= rd_en;
      if (rd_en) begin
        mem_q_reg    <= mem[rd_addr];
        byp_be_reg   <= collide ? wr_be : '0;
        byp_data_reg <= wr_data;
        byp_par_reg  <= wr_par;
      end
    end
  end

  if (PARITY_EN != 0) begin : g_par
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] par_q_reg;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_be[i]) begin
            par_mem[wr_addr][i] <= wr_par[i];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        par_q_reg <= '0;
      end else if (rd_en) begin
        par_q_reg <= par_mem[rd_addr];
      end
    end

    assign par_q = par_q_reg;
  end else begin : g_nopar
    assign par_q = '0;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
    assign merged_data[gi*BYTE_WIDTH +: BYTE_WIDTH] = byp_be_reg[gi]
        ? byp_data_reg[gi*BYTE_WIDTH +: BYTE_WIDTH]
        : mem_q_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
    assign merged_par[gi] = byp_be_reg[gi] ? byp_par_reg[gi] : par_q[gi];
  end

  assign chk_par = LANES'(lane_parity(PAR_MAX_DATA_W'(merged_data), LANES, BYTE_WIDTH)) ^ merged_par;
  assign perr1   = (PARITY_EN != 0) && (|chk_par);

  ram_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (DATA_WIDTH + 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_valid1_reg),
    .in_data   ({perr1, merged_data}),
    .out_valid (rd_valid),
    .out_data  (pipe_out)
  );

  assign rd_perr = pipe_out[DATA_WIDTH];
  assign rd_data = pipe_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_dp_block_ram.sv
// Directed bench: two instances share the input stimulus; dut_a is latency 1 /
// READ_OLD / no parity, dut_b is latency 2 / WRITE_FIRST / parity.
module tb_dp_block_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_perr_inj;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;
  logic        a_rd_perr, b_rd_perr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_block_ram #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10),
    .READ_LATENCY(1), .RDW_MODE(0), .PARITY_EN(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_perr_inj(wr_perr_inj),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_perr(a_rd_perr)
  );

  dp_block_ram #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10),
    .READ_LATENCY(2), .RDW_MODE(1), .PARITY_EN(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_perr_inj(wr_perr_inj),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_perr(b_rd_perr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [9:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic inj);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be; wr_perr_inj = inj;
    tick();
    wr_en = 1'b0; wr_be = 4'h0; wr_perr_inj = 1'b0;
    $display("write addr %0d data %h be %b inj %0b", addr, data, be, inj);
  endtask

  task automatic read_one(input string tag, input logic [9:0] addr,
                          input logic [31:0] exp_a, input logic [31:0] exp_b,
                          input logic exp_b_perr);
    rd_en = 1'b1; rd_addr = addr;
    tick();
    rd_en = 1'b0;
    check({tag, "_a_valid"}, 32'(a_rd_valid), 32'd1);
    check({tag, "_a_data"},  a_rd_data, exp_a);
    check({tag, "_b_early"}, 32'(b_rd_valid), 32'd0);
    tick();
    check({tag, "_b_valid"}, 32'(b_rd_valid), 32'd1);
    check({tag, "_b_data"},  b_rd_data, exp_b);
    check({tag, "_b_perr"},  32'(b_rd_perr), 32'(exp_b_perr));
    check({tag, "_a_pulse"}, 32'(a_rd_valid), 32'd0);
    $display("read %s addr %0d a=%h b=%h b_perr=%0b", tag, addr, a_rd_data, b_rd_data, b_rd_perr);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0; wr_perr_inj = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_a_valid", 32'(a_rd_valid), 32'd0);
    check("rst_a_data",  a_rd_data, 32'h0);
    check("rst_a_perr",  32'(a_rd_perr), 32'd0);
    check("rst_b_valid", 32'(b_rd_valid), 32'd0);
    check("rst_b_data",  b_rd_data, 32'h0);
    check("rst_b_perr",  32'(b_rd_perr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full fill, then back-to-back read of every address.
    for (int k = 0; k < 1024; k++) begin
      wr_en = 1'b1; wr_addr = 10'(k); wr_data = 32'hA500_0000 | 32'(k); wr_be = 4'hF;
      tick();
    end
    wr_en = 1'b0; wr_be = 4'h0;
    for (int c = 0; c < 1026; c++) begin
      rd_en = (c < 1024); rd_addr = 10'(c);
      tick();
      check("bulk_a_valid", 32'(a_rd_valid), 32'(c < 1024));
      if (c < 1024) check("bulk_a_data", a_rd_data, 32'hA500_0000 | 32'(c));
      check("bulk_b_valid", 32'(b_rd_valid), 32'(c >= 1 && c <= 1024));
      if (c >= 1 && c <= 1024) begin
        check("bulk_b_data", b_rd_data, 32'hA500_0000 | 32'(c - 1));
        check("bulk_b_perr", 32'(b_rd_perr), 32'd0);
      end
    end
    rd_en = 1'b0;
    $display("bulk readback of 1024 words done");

    // Byte enables.
    write_word(10'd5, 32'h1122_3344, 4'hF, 1'b0);
    write_word(10'd5, 32'hAABB_CCDD, 4'b0101, 1'b0);
    read_one("be", 10'd5, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0);

    // Same-cycle collision, full word.
    write_word(10'd7, 32'h0, 4'hF, 1'b0);
    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 10'd7;
    tick();
    wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
    check("col_a_data", a_rd_data, 32'h0);
    tick();
    check("col_b_valid", 32'(b_rd_valid), 32'd1);
    check("col_b_data",  b_rd_data, 32'hDEAD_BEEF);
    $display("collision addr 7 a=%h b=%h", a_rd_data, b_rd_data);
    read_one("col_after", 10'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    // Same-cycle collision, partial lanes.
    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 32'h0; wr_be = 4'b0101;
    rd_en = 1'b1; rd_addr = 10'd7;
    tick();
    wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
    check("pcol_a_data", a_rd_data, 32'hDEAD_BEEF);
    tick();
    check("pcol_b_data", b_rd_data, 32'hDE00_BE00);
    $display("partial collision addr 7 a=%h b=%h", a_rd_data, b_rd_data);
    read_one("pcol_after", 10'd7, 32'hDE00_BE00, 32'hDE00_BE00, 1'b0);

    // Parity injection and clean rewrite.
    write_word(10'd3, 32'h1234_5678, 4'hF, 1'b0);
    write_word(10'd3, 32'h0000_AB00, 4'b0010, 1'b1);
    read_one("inj", 10'd3, 32'h1234_AB78, 32'h1234_AB78, 1'b1);
    write_word(10'd3, 32'h0000_CD00, 4'b0010, 1'b0);
    read_one("clean", 10'd3, 32'h1234_CD78, 32'h1234_CD78, 1'b0);
    read_one("other", 10'd4, 32'hA500_0004, 32'hA500_0004, 1'b0);
    wr_en = 1'b1; wr_addr = 10'd3; wr_data = 32'h0000_EF00; wr_be = 4'b0010; wr_perr_inj = 1'b1;
    rd_en = 1'b1; rd_addr = 10'd3;
    tick();
    wr_en = 1'b0; wr_be = 4'h0; wr_perr_inj = 1'b0; rd_en = 1'b0;
    check("injcol_a_data", a_rd_data, 32'h1234_CD78);
    tick();
    check("injcol_b_data", b_rd_data, 32'h1234_EF78);
    check("injcol_b_perr", 32'(b_rd_perr), 32'd1);
    $display("injected collision addr 3 b=%h perr=%0b", b_rd_data, b_rd_perr);

    // Reset with reads in flight.
    rd_en = 1'b1; rd_addr = 10'd10;
    tick();
    rd_addr = 10'd11;
    tick();
    rd_en = 1'b0;
    check("mid_b_valid", 32'(b_rd_valid), 32'd1);
    check("mid_b_data",  b_rd_data, 32'hA500_000A);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_a_valid", 32'(a_rd_valid), 32'd0);
    check("arst_a_data",  a_rd_data, 32'h0);
    check("arst_b_valid", 32'(b_rd_valid), 32'd0);
    check("arst_b_data",  b_rd_data, 32'h0);
    check("arst_b_perr",  32'(b_rd_perr), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_a_valid", 32'(a_rd_valid), 32'd0);
      check("post_rst_b_valid", 32'(b_rd_valid), 32'd0);
    end
    $display("reset mid-flight done");
    read_one("post_rst", 10'd12, 32'hA500_000C, 32'hA500_000C, 1'b0);

    // Hold while writing elsewhere.
    write_word(10'd20, 32'hCAFE_F00D, 4'hF, 1'b0);
    read_one("hold", 10'd20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      write_word(10'(21 + i), 32'(i), 4'hF, 1'b0);
      check("hold_a_data",  a_rd_data, 32'hCAFE_F00D);
      check("hold_a_valid", 32'(a_rd_valid), 32'd0);
      check("hold_b_data",  b_rd_data, 32'hCAFE_F00D);
      check("hold_b_valid", 32'(b_rd_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
